// File: rtl/dct_twiddle_gen.sv
// rtl/dct_twiddle_gen.sv - DCT/IDCT rotation coefficient generator, cos/sin(pi*k/2N), 3-cycle latency
//
// Ports:
//   clk, rst_sync        rising-edge clock, synchronous active-high reset
//   sink_valid           one coefficient requested this cycle
//   sink_sop, sink_eop   frame markers, qualified by sink_valid
//   log2n_in, inv_mode   frame size and direction, sampled on sop beats only
//   source_valid         output beat valid (three cycles after the request)
//   source_sop/eop       frame markers aligned with the coefficients
//   source_k             index k of this beat
//   source_cos/sin       signed coefficients scaled by 2^(W_COEF-2)
//   source_error         bad frame size, or sink_eop away from k = N-1
//
// The quarter-wave table (NMAX+1 words, word i = round(AMP*cos(pi*i/(2*NMAX))))
// is computed at elaboration by an integer-only series, so no image file is needed.
module dct_twiddle_gen #(
    parameter int W_COEF     = 18,
    parameter int LOG2_NMAX  = 11,
    parameter int SQRT2_COEF = 92682
) (
    input  logic                        clk,
    input  logic                        rst_sync,
    input  logic                        sink_valid,
    input  logic                        sink_sop,
    input  logic                        sink_eop,
    input  logic [3:0]                  log2n_in,
    input  logic                        inv_mode,
    output logic                        source_valid,
    output logic                        source_sop,
    output logic                        source_eop,
    output logic [LOG2_NMAX-1:0]        source_k,
    output logic signed [W_COEF-1:0]    source_cos,
    output logic signed [W_COEF-1:0]    source_sin,
    output logic                        source_error
);

    localparam int NMAX = 1 << LOG2_NMAX;
    localparam int AW   = LOG2_NMAX + 1;
    localparam logic [W_COEF-1:0] AMP_WORD   = W_COEF'(1) << (W_COEF - 2);
    localparam logic [W_COEF-1:0] SQRT2_WORD = W_COEF'(SQRT2_COEF);
    // pi in Q60
    localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

    if (SQRT2_COEF >= (1 << (W_COEF - 1))) begin : g_bad_sqrt2
        $error("SQRT2_COEF does not fit a signed W_COEF-bit word");
    end

    // Taylor series for cos in Q60; truncation error stays far below half an output LSB.
    function automatic logic [W_COEF-1:0] cos_word(input int idx);
        logic signed [127:0] x, x2, term, sum, den;
        x    = (PI_Q60 * 128'(idx)) / 128'(2 * NMAX);
        x2   = (x * x) >>> 60;
        term = 128'sd1 <<< 60;
        sum  = term;
        for (int n = 1; n <= 15; n++) begin
            den  = 128'((2 * n - 1) * (2 * n));
            term = -(((term * x2) >>> 60) / den);
            sum  = sum + term;
        end
        cos_word = W_COEF'((sum * (128'sd1 <<< (W_COEF - 2)) + (128'sd1 <<< 59)) >>> 60);
    endfunction

    logic [W_COEF-1:0] w_rom [0:NMAX];
    for (genvar gi = 0; gi <= NMAX; gi++) begin : g_rom
        localparam logic [W_COEF-1:0] C_WORD = cos_word(gi);
        assign w_rom[gi] = C_WORD;
    end

    // Frame state
    logic [LOG2_NMAX-1:0] r_k;
    logic [3:0]           r_log2n;
    logic                 r_inv;
    logic                 r_frame_err;

    // Beat decode
    logic                 w_size_ok;
    logic [3:0]           w_log2n;
    logic                 w_inv;
    logic                 w_frame_err;
    logic [LOG2_NMAX-1:0] w_k;
    logic [3:0]           w_shift;
    logic [AW-1:0]        w_n;
    logic [AW-1:0]        w_addr;
    logic                 w_last;
    logic                 w_sop;
    logic                 w_err;

    // Pipeline
    logic                 r1_valid, r1_sop, r1_eop, r1_err, r1_inv;
    logic [LOG2_NMAX-1:0] r1_k;
    logic [AW-1:0]        r1_addr_cos, r1_addr_sin;
    logic                 r2_valid, r2_sop, r2_eop, r2_err, r2_inv;
    logic [LOG2_NMAX-1:0] r2_k;
    logic [W_COEF-1:0]    r2_cos_rom, r2_sin_rom;
    logic                 r3_valid, r3_sop, r3_eop, r3_err;
    logic [LOG2_NMAX-1:0] r3_k;
    logic [W_COEF-1:0]    r3_cos, r3_sin;

    always_comb begin
        w_size_ok = (log2n_in >= 4'd5) && (log2n_in <= 4'(LOG2_NMAX));
        // On a sop beat the freshly sampled size/mode already apply to this beat.
        if (sink_sop) begin
            w_log2n     = w_size_ok ? log2n_in : 4'(LOG2_NMAX);
            w_inv       = inv_mode;
            w_frame_err = ~w_size_ok;
            w_k         = '0;
        end else begin
            w_log2n     = r_log2n;
            w_inv       = r_inv;
            w_frame_err = r_frame_err;
            w_k         = r_k;
        end
        w_shift = 4'(LOG2_NMAX) - w_log2n;
        w_n     = AW'(1) << w_log2n;
        w_last  = ({1'b0, w_k} == (w_n - AW'(1)));
        // k = 0 starts a frame whether it came from sink_sop or from the wrap.
        w_sop   = (w_k == '0);
        w_err   = w_frame_err | (sink_eop & ~w_last);
        w_addr  = {1'b0, w_k} << w_shift;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_k         <= '0;
            r_log2n     <= 4'(LOG2_NMAX);
            r_inv       <= 1'b1;
            r_frame_err <= 1'b0;
            r1_valid    <= 1'b0;
            r1_sop      <= 1'b0;
            r1_eop      <= 1'b0;
            r1_err      <= 1'b0;
            r1_inv      <= 1'b0;
            r1_k        <= '0;
            r1_addr_cos <= '0;
            r1_addr_sin <= '0;
            r2_valid    <= 1'b0;
            r2_sop      <= 1'b0;
            r2_eop      <= 1'b0;
            r2_err      <= 1'b0;
            r2_inv      <= 1'b0;
            r2_k        <= '0;
            r2_cos_rom  <= '0;
            r2_sin_rom  <= '0;
            r3_valid    <= 1'b0;
            r3_sop      <= 1'b0;
            r3_eop      <= 1'b0;
            r3_err      <= 1'b0;
            r3_k        <= '0;
            r3_cos      <= '0;
            r3_sin      <= '0;
        end else begin
            // Flags shift every cycle, masked by valid; k and data hold across gaps.
            r1_valid <= sink_valid;
            r1_sop   <= sink_valid & w_sop;
            r1_eop   <= sink_valid & w_last;
            r1_err   <= sink_valid & w_err;
            r2_valid <= r1_valid;
            r2_sop   <= r1_sop;
            r2_eop   <= r1_eop;
            r2_err   <= r1_err;
            r3_valid <= r2_valid;
            r3_sop   <= r2_sop;
            r3_eop   <= r2_eop;
            r3_err   <= r2_err;

            if (sink_valid) begin
                r_k         <= w_last ? '0 : w_k + LOG2_NMAX'(1);
                r_log2n     <= w_log2n;
                r_inv       <= w_inv;
                r_frame_err <= w_frame_err;
                r1_k        <= w_k;
                r1_inv      <= w_inv;
                r1_addr_cos <= w_addr;
                // sin(x) = cos(pi/2 - x): mirror the address across the quarter wave.
                r1_addr_sin <= AW'(NMAX) - w_addr;
            end

            if (r1_valid) begin
                r2_k       <= r1_k;
                r2_inv     <= r1_inv;
                r2_cos_rom <= w_rom[r1_addr_cos];
                r2_sin_rom <= w_rom[r1_addr_sin];
            end

            if (r2_valid) begin
                r3_k <= r2_k;
                if (r2_k == '0) begin
                    r3_cos <= r2_inv ? SQRT2_WORD : AMP_WORD;
                    r3_sin <= '0;
                end else begin
                    r3_cos <= r2_cos_rom;
                    // Table words are in 0..AMP, so the negation always fits.
                    r3_sin <= r2_inv ? r2_sin_rom : -r2_sin_rom;
                end
            end
        end
    end

    assign source_valid = r3_valid;
    assign source_sop   = r3_sop;
    assign source_eop   = r3_eop;
    assign source_error = r3_err;
    assign source_k     = r3_k;
    assign source_cos   = $signed(r3_cos);
    assign source_sin   = $signed(r3_sin);

endmodule
